// File: rtl/mem_port_arbiter_if.sv
// Requester/memory bundle for mem_port_arbiter.
//   req/we/addr/wdata : per-port request, slice i belongs to port i
//   gnt/rvalid        : registered per-port grant and read-data-valid
//   rdata             : read data broadcast to every port
//   mem_we/mem_addr/mem_wdata/mem_rdata : single-port memory side
interface mem_port_arbiter_if #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0]            we;
    logic [N_REQ*ADDR_WIDTH-1:0] addr;
    logic [N_REQ*DATA_WIDTH-1:0] wdata;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rvalid;
    logic [DATA_WIDTH-1:0]       rdata;
    logic                        mem_we;
    logic [ADDR_WIDTH-1:0]       mem_addr;
    logic [DATA_WIDTH-1:0]       mem_wdata;
    logic [DATA_WIDTH-1:0]       mem_rdata;

    // Arbiter side
    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );

    // Requesters plus memory side
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide synchronous memory among N_REQ
// requesters, with sticky burst grants capped at MAX_BURST beats while
// another port waits.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requests, grants, memory port)
module mem_port_arbiter #(
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    logic [0:0]       state, state_n;
    logic [IW-1:0]    owner, owner_n;
    logic [IW-1:0]    rr_ptr, rr_ptr_n;
    logic [CW-1:0]    beat_cnt, beat_cnt_n;
    logic [N_REQ-1:0] gnt_q, gnt_n;
    logic [N_REQ-1:0] rvalid_q, rvalid_n;

    logic             beat;
    logic [N_REQ-1:0] others;
    logic [IW-1:0]    nxt_ptr;
    logic [IW-1:0]    win_rr;
    logic [IW-1:0]    win_nx;

    logic [ADDR_WIDTH-1:0] addr_a  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_a [N_REQ];

    // First requesting index at or above start, wrapping modulo N_REQ
    function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] r,
                                           input logic [IW-1:0]    start);
        logic [IW-1:0] w;
        logic [IW-1:0] idx;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IW'((32'(start) + i) % N_REQ);
            if (!found && r[idx]) begin
                w     = idx;
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        return N_REQ'(1) << i;
    endfunction

    // Per-port slices of the flat address/data buses
    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_a[g]  = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_a[g] = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign beat    = |(gnt_q & bus.req);
    assign others  = bus.req & ~onehot(owner);
    assign nxt_ptr = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
    assign win_rr  = pick(bus.req, rr_ptr);
    // On release req[owner] is low, so searching the others covers both cases
    assign win_nx  = pick(others, nxt_ptr);

    // Memory port follows the owner only while a beat is in progress
    assign bus.mem_we    = beat & bus.we[owner];
    assign bus.mem_addr  = beat ? addr_a[owner]  : '0;
    assign bus.mem_wdata = beat ? wdata_a[owner] : '0;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.gnt       = gnt_q;
    assign bus.rvalid    = rvalid_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_ptr_n;
            beat_cnt <= beat_cnt_n;
            gnt_q    <= gnt_n;
            rvalid_q <= rvalid_n;
        end
    end

    // Next-state: arbitration, release, preemption
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        beat_cnt_n = beat_cnt;
        gnt_n      = gnt_q;
        rvalid_n   = '0;

        if (beat && !bus.we[owner]) begin
            rvalid_n = onehot(owner);
        end

        case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    owner_n    = win_rr;
                    gnt_n      = onehot(win_rr);
                    beat_cnt_n = '0;
                    state_n    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!bus.req[owner]) begin
                    rr_ptr_n = nxt_ptr;
                    if (|bus.req) begin
                        owner_n    = win_nx;
                        gnt_n      = onehot(win_nx);
                        beat_cnt_n = '0;
                    end else begin
                        gnt_n   = '0;
                        state_n = ST_IDLE;
                    end
                end else if ((beat_cnt >= CNT_LAST) && (|others)) begin
                    // Burst cap reached with someone waiting: hand over
                    rr_ptr_n   = nxt_ptr;
                    owner_n    = win_nx;
                    gnt_n      = onehot(win_nx);
                    beat_cnt_n = '0;
                end else if (beat_cnt != CNT_MAX) begin
                    beat_cnt_n = beat_cnt + CW'(1);
                end
            end
            default: begin
                gnt_n   = '0;
                state_n = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Power-up contents of the memory; 0x0100 holds 0x5A
    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5B;
    endfunction

    // Behavioural simple_memory: 1-cycle synchronous read
    logic [7:0] mem_wr [int];
    always @(posedge clk) begin : memory
        logic [7:0] rd;
        rd = mem_wr.exists(int'(bus.mem_addr)) ? mem_wr[int'(bus.mem_addr)] : init_byte(bus.mem_addr);
        if (bus.mem_we) mem_wr[int'(bus.mem_addr)] = bus.mem_wdata;
        bus.mem_rdata <= rd;
    end

    // Reference memory image
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
    endfunction

    // Requester agents
    int          rem        [N];
    logic [15:0] cur_addr   [N];
    logic        cur_we     [N];
    logic [7:0]  cur_wd     [N];
    int          b_mode     [N];
    logic [7:0]  b_data     [N];
    int          beats_done [N];

    // Reference arbiter state
    bit         m_busy;
    int         m_owner, m_ptr, m_cnt;
    logic [N-1:0] e_gnt, e_rv, m_beat;
    logic [7:0] e_rdata;

    // Observations
    int         beat_log [$];
    logic [7:0] last_rd  [N];
    int         n_rv     [N];
    int         n_we_cycles = 0;

    function automatic int first_from(input logic [N-1:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req[i]            = (rem[i] > 0);
            bus.we[i]             = cur_we[i];
            bus.addr[i*AW +: AW]  = cur_addr[i];
            bus.wdata[i*DW +: DW] = cur_wd[i];
        end
    endtask

    task automatic new_beat_vals(input int i);
        cur_we[i] = (b_mode[i] == 0) ? 1'b0 : (b_mode[i] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cur_wd[i] = (b_mode[i] == 1) ? b_data[i] : 8'($urandom);
    endtask

    task automatic start_burst(input int p, input int len, input logic [15:0] base,
                               input int mode, input logic [7:0] data);
        rem[p]      = len;
        cur_addr[p] = base;
        b_mode[p]   = mode;
        b_data[p]   = data;
        new_beat_vals(p);
        drive();
    endtask

    task automatic check_outputs();
        logic beat;
        int   o, obs;
        o    = m_owner;
        beat = m_busy && bus.req[o];
        check("gnt", 32'(bus.gnt), 32'(e_gnt));
        check("gnt_onehot", 32'($countones(bus.gnt) <= 1), 32'd1);
        check("rvalid", 32'(bus.rvalid), 32'(e_rv));
        if (e_rv != '0) check("rdata", 32'(bus.rdata), 32'(e_rdata));
        check("mem_we",    32'(bus.mem_we),    beat ? 32'(cur_we[o])   : 32'd0);
        check("mem_addr",  32'(bus.mem_addr),  beat ? 32'(cur_addr[o]) : 32'd0);
        check("mem_wdata", 32'(bus.mem_wdata), beat ? 32'(cur_wd[o])   : 32'd0);
        obs = -1;
        for (int i = 0; i < N; i++) begin
            if (bus.gnt[i] && bus.req[i]) obs = i;
            if (bus.rvalid[i]) begin
                last_rd[i] = bus.rdata;
                n_rv[i]++;
            end
        end
        beat_log.push_back(obs);
        if (bus.mem_we) n_we_cycles++;
    endtask

    task automatic grant(input int w);
        m_owner = w;
        m_busy  = 1'b1;
        m_cnt   = 0;
        e_gnt   = N'(1) << w;
    endtask

    task automatic model_step();
        logic         beat;
        logic [N-1:0] oth;
        int           o;
        o      = m_owner;
        beat   = m_busy && bus.req[o];
        m_beat = beat ? (N'(1) << o) : '0;
        e_rv   = '0;
        if (beat) begin
            if (!cur_we[o]) begin
                e_rv[o] = 1'b1;
                e_rdata = ref_rd(cur_addr[o]);
            end else begin
                ref_mem[int'(cur_addr[o])] = cur_wd[o];
            end
        end
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            e_gnt  = '0; e_rv = '0;
        end else if (!m_busy) begin
            if (bus.req != '0) grant(first_from(bus.req, m_ptr));
        end else if (!bus.req[o]) begin
            m_ptr = (o + 1) % N;
            if (bus.req != '0) grant(first_from(bus.req, m_ptr));
            else begin
                m_busy = 0;
                e_gnt  = '0;
            end
        end else begin
            oth = bus.req & ~(N'(1) << o);
            if (m_cnt >= MB - 1 && oth != '0) begin
                m_ptr = (o + 1) % N;
                grant(first_from(oth, m_ptr));
            end else if (m_cnt < MB) begin
                m_cnt++;
            end
        end
    endtask

    task automatic agents_update(input bit rand_en);
        for (int i = 0; i < N; i++) begin
            if (m_beat[i]) begin
                rem[i]--;
                cur_addr[i]++;
                beats_done[i]++;
                new_beat_vals(i);
            end
            if (rand_en && rem[i] == 0 && $urandom_range(0, 7) == 0)
                start_burst(i, int'($urandom_range(1, 12)), 16'($urandom), 2, 8'h00);
        end
        drive();
    endtask

    task automatic tick(input bit rand_en);
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        agents_update(rand_en);
        cyc++;
    endtask

    function automatic bit any_pending();
        for (int i = 0; i < N; i++) if (rem[i] > 0) return 1'b1;
        return m_busy;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (any_pending() && n < budget) begin
            tick(0);
            n++;
        end
        check("idle_timeout", 32'(any_pending()), 32'd0);
        tick(0);
        tick(0);
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        tick(0);
        rst_n = 1'b1;
    endtask

    task automatic clear_obs();
        beat_log.delete();
        for (int i = 0; i < N; i++) begin
            beats_done[i] = 0;
            n_rv[i]       = 0;
        end
        n_we_cycles = 0;
    endtask

    // Collapse beat log into (port, run length) pairs
    int run_port [$];
    int run_len  [$];
    task automatic build_runs();
        run_port.delete();
        run_len.delete();
        foreach (beat_log[k]) begin
            if (beat_log[k] >= 0) begin
                if (run_port.size() > 0 && run_port[$] == beat_log[k])
                    run_len[run_len.size()-1]++;
                else begin
                    run_port.push_back(beat_log[k]);
                    run_len.push_back(1);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, rs_idx, first1;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; cur_addr[i] = '0; cur_we[i] = 1'b0; cur_wd[i] = '0;
            b_mode[i] = 0; b_data[i] = '0; beats_done[i] = 0; last_rd[i] = '0; n_rv[i] = 0;
        end
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        e_gnt = '0; e_rv = '0; e_rdata = '0; m_beat = '0;
        drive();
        rst_n = 1'b0;
        repeat (3) tick(0);
        rst_n = 1'b1;

        // Single read of 0x0100
        clear_obs();
        start_burst(1, 1, 16'h0100, 0, 8'h00);
        wait_idle(20);
        first1 = -1;
        foreach (beat_log[j]) if (first1 < 0 && beat_log[j] == 1) first1 = j;
        check("single_read_latency", 32'(first1), 32'd1);
        check("single_read_data", 32'(last_rd[1]), 32'h5A);
        check("single_read_rvalid_cnt", 32'(n_rv[1]), 32'd1);
        check("single_read_no_write", 32'(n_we_cycles), 32'd0);

        // Round-robin tie between ports 0 and 2 from reset
        reset_cycle();
        clear_obs();
        start_burst(0, 2, 16'h1000, 0, 8'h00);
        start_burst(2, 2, 16'h1100, 0, 8'h00);
        wait_idle(30);
        check("tie_first", 32'(beat_log[1]), 32'd0);
        check("tie_gap", 32'(beat_log[3]), 32'hFFFF_FFFF);
        check("tie_second", 32'(beat_log[4]), 32'd2);
        check("tie_rr_ptr", 32'(dut.rr_ptr), 32'd0);

        // Burst preemption: port 0 ten beats, port 1 joins at beat 2
        clear_obs();
        start_burst(0, 10, 16'h2000, 0, 8'h00);
        k = 0;
        while (beats_done[0] < 2 && k < 20) begin
            tick(0);
            k++;
        end
        check("pre_wait", 32'(beats_done[0]), 32'd2);
        start_burst(1, 3, 16'h3000, 2, 8'h00);
        wait_idle(60);
        build_runs();
        check("pre_nruns", 32'(run_port.size()), 32'd3);
        if (run_port.size() == 3) begin
            check("pre_run0_port", 32'(run_port[0]), 32'd0);
            check("pre_run0_len",  32'(run_len[0]),  32'd4);
            check("pre_run1_port", 32'(run_port[1]), 32'd1);
            check("pre_run1_len",  32'(run_len[1]),  32'd3);
            check("pre_run2_port", 32'(run_port[2]), 32'd0);
            check("pre_run2_len",  32'(run_len[2]),  32'd6);
        end
        check("pre_end_addr", 32'(cur_addr[0]), 32'h200A);

        // Write passthrough then readback
        clear_obs();
        start_burst(2, 1, 16'h7FFF, 1, 8'hC3);
        wait_idle(20);
        check("wr_we_cycles", 32'(n_we_cycles), 32'd1);
        check("wr_no_rvalid", 32'(n_rv[2]), 32'd0);
        start_burst(0, 1, 16'h7FFF, 0, 8'h00);
        wait_idle(20);
        check("wr_readback", 32'(last_rd[0]), 32'hC3);

        // Reset in the middle of a read burst
        clear_obs();
        start_burst(1, 6, 16'h4000, 0, 8'h00);
        k = 0;
        while (beats_done[1] < 2 && k < 20) begin
            tick(0);
            k++;
        end
        check("rst_wait", 32'(beats_done[1]), 32'd2);
        reset_cycle();
        rs_idx = beat_log.size();
        tick(0);
        tick(0);
        check("rst_dead_cycle", 32'(beat_log[rs_idx]), 32'hFFFF_FFFF);
        check("rst_regrant", 32'(beat_log[rs_idx+1]), 32'd1);
        wait_idle(30);

        // Single long streamer is never preempted
        clear_obs();
        start_burst(2, 200, 16'h8000, 2, 8'h00);
        wait_idle(400);
        build_runs();
        check("sat_nruns", 32'(run_port.size()), 32'd1);
        if (run_len.size() > 0) check("sat_len", 32'(run_len[0]), 32'd200);

        // Random traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port byte-wide unified memory (simple_memory) among N requesters: port 0 fetch unit, port 1 execution unit, port 2 host loader/debug.
- Replaces the state-based address mux in the accelerator top.
- Uses round-robin arbitration with sticky burst grants.
- A burst-length cap guarantees forward progress for every requester.

Parameters:
- N_REQ, 3, number of requester ports (≥2).
- ADDR_WIDTH, 16, memory byte-address width.
- DATA_WIDTH, 8, memory data width.
- MAX_BURST, 64, consecutive beats an owner may take while another requester waits (≥1).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-port request; held high for the whole burst.
- we  in  N_REQ  per-port write enable; valid with req.
- addr  in  N_REQ*ADDR_WIDTH  per-port address; slice i is port i.
- wdata  in  N_REQ*DATA_WIDTH  per-port write data.
- gnt  out  N_REQ  registered one-hot grant.
- rvalid  out  N_REQ  read data valid for port i.
- rdata  out  DATA_WIDTH  read data, broadcast to all ports (mem_rdata passthrough).
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data; 1-cycle synchronous read.

Behaviour:
- **Reset** (rst_n low at a clock edge, including mid-burst):
  - gnt=0, rvalid=0, state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - Memory outputs are 0 while gnt=0.
  - An in-flight read's rvalid is suppressed.
- **Beat:** a cycle with gnt[i]&req[i].
  - mem_we/mem_addr/mem_wdata are driven combinationally from port i's slice.
  - When no beat occurs: mem_we=0, mem_addr=0, mem_wdata=0. A memory write never happens without a beat.
- **Read latency:** rvalid[i] is registered and goes high exactly 1 cycle after a read beat (we[i]=0) of port i. rdata is valid in that same cycle.
  - Write beats produce no rvalid.
  - Back-to-back read beats give back-to-back rvalid.
- **State IDLE:**
  - If any req is high, pick winner w = first requesting index searching upward from rr_ptr, wrapping modulo N_REQ.
  - Next cycle: gnt=onehot(w), owner=w, beat_cnt=0, state GRANT.
  - Arbitration latency is 1 cycle from req to gnt. No beat occurs in IDLE.
- **State GRANT:**
  - **Beat cycle:** beat_cnt increments (saturating at MAX_BURST).
  - **Release:** when req[owner]=0, the cycle is not a beat.
    - rr_ptr <= (owner+1) mod N_REQ.
    - If another req is high, the new winner is selected using the updated pointer (search from owner+1). gnt moves to it next cycle and beat_cnt=0. The bus is dead for only 1 cycle.
    - Otherwise gnt=0 and state returns to IDLE.
  - **Preemption:** a beat with beat_cnt==MAX_BURST-1 while any other req is high.
    - gnt[owner] drops next cycle.
    - Next owner is selected from owner+1 as in release.
    - The preempted port keeps req high and simply waits; it loses no data.
    - If no other req is high, the owner keeps the grant and beat_cnt holds at MAX_BURST.
    - Once beat_cnt is saturated, any newly arriving other req triggers preemption after the next beat.
- **Simultaneous events:**
  - Release and a new req in the same cycle: the new req competes in that cycle's selection.
  - A req that rises and falls while not granted is ignored; no beat occurs.
- **Invariants:**
  - gnt is one-hot or zero at all times.
  - gnt only changes on the cycle after release, preemption, or reset.
  - Requesters must not change addr/we/wdata semantics except per beat. The arbiter does not buffer requests.

Test Plan:
- **Single read:** port 1 req, we=0, addr=0x0100 for 1 beat, memory holds 0x5A → gnt[1] one cycle after req; rvalid[1]=1 and rdata=0x5A the cycle after the beat; mem_we never high.
- **Round-robin tie:** ports 0 and 2 raise req together from reset (rr_ptr=0), each doing a 2-beat burst → port 0 granted first; after port 0 drops req, port 2 granted with a 1-cycle gap; rr_ptr=0 afterwards.
- **Burst preemption:** MAX_BURST=4; port 0 holds req for 10 beats, port 1 requests at beat 2 → port 0 gets exactly 4 beats; port 1 is granted and runs its 3-beat burst; port 0 is regranted and finishes the remaining 6 beats; the address sequence is intact.
- **Write passthrough:** port 2 writes 0xC3 to 0x7FFF → mem_we=1, mem_addr=0x7FFF, mem_wdata=0xC3 for exactly one cycle; no rvalid; a readback by port 0 returns 0xC3.
- **Reset mid-burst:** assert rst_n=0 during port 1's read burst, with one read in flight → next cycle gnt=0, rvalid=0, mem_we=0; after release with port 1 req still high, gnt[1] is reasserted 1 cycle later.
- **Idle/saturation:** a single requester streams 200 beats with MAX_BURST=64 and no other req → never preempted; gnt[owner] stays high throughout; zero dead cycles.
